// File: rtl/loa_add_arbiter_if.sv
// Request/result bus of the shared LOA adder: NREQ operand requesters
// on one side, a single registered result stream on the other.
interface loa_add_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
);
  localparam int ID_W = $clog2(NREQ);

  logic                    approx_en;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*WIDTH-1:0]   req_a;
  logic [NREQ*WIDTH-1:0]   req_b;
  logic [NREQ-1:0]         req_ready;
  logic                    res_valid;
  logic [WIDTH-1:0]        res_data;
  logic                    res_cout;
  logic [ID_W-1:0]         res_id;
  logic                    res_ready;

  // Requester/consumer side
  modport master (
    output approx_en, req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_cout, res_id
  );

  // Adder side
  modport slave (
    input  approx_en, req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_cout, res_id
  );
endinterface

// File: rtl/loa_add_arbiter.sv
// Round-robin arbiter in front of one shared adder. Each granted request
// is summed either exactly or with a lower-part OR approximation (LOA) and
// the result is held in a single output register until the consumer takes it.
module loa_add_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 16,
  parameter int LOA_BITS = 8
) (
  input logic               clk,
  input logic               rst_n,
  loa_add_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(NREQ);

  // Exact or LOA sum, returned as {carry_out, sum}.
  function automatic logic [WIDTH:0] loa_sum(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             approx
  );
    logic [WIDTH-LOA_BITS:0] hi;
    logic                    carry_in;
    if (!approx) begin
      return {1'b0, a} + {1'b0, b};
    end
    // The top OR'ed bit pair stands in for the carry the lower part would produce
    carry_in = a[LOA_BITS-1] & b[LOA_BITS-1];
    hi = {1'b0, a[WIDTH-1:LOA_BITS]} + {1'b0, b[WIDTH-1:LOA_BITS]}
       + {{(WIDTH-LOA_BITS){1'b0}}, carry_in};
    return {hi, a[LOA_BITS-1:0] | b[LOA_BITS-1:0]};
  endfunction

  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  winner;
  logic             found;
  logic             adder_free;
  logic             xfer;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH:0]   sum_p0;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic             cout_p1;
  logic [ID_W-1:0]  id_p1;

  assign adder_free = !vld_p1 || bus.res_ready;

  // Round-robin search starting one past the last granted requester
  always_comb begin
    int j;
    winner = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(last_grant) + k) % NREQ;
      if (!found && bus.req_valid[j]) begin
        found  = 1'b1;
        winner = ID_W'(j);
      end
    end
  end

  // Grant is held off during reset so nothing is accepted while rst_n is low
  assign xfer          = found && adder_free && rst_n;
  assign bus.req_ready = xfer ? (NREQ'(1) << winner) : '0;

  // ---- stage p0: operand select and add ----
  assign a_sel  = bus.req_a[int'(winner)*WIDTH +: WIDTH];
  assign b_sel  = bus.req_b[int'(winner)*WIDTH +: WIDTH];
  assign sum_p0 = loa_sum(a_sel, b_sel, bus.approx_en);

  // Arbitration pointer advances only on an accepted transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ID_W'(NREQ - 1);
    end else if (xfer) begin
      last_grant <= winner;
    end
  end

  // ---- stage p1: result register, held under backpressure ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      cout_p1 <= 1'b0;
      id_p1   <= '0;
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= sum_p0[WIDTH-1:0];
      cout_p1 <= sum_p0[WIDTH];
      id_p1   <= winner;
    end else if (bus.res_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.res_valid = vld_p1;
  assign bus.res_data  = data_p1;
  assign bus.res_cout  = cout_p1;
  assign bus.res_id    = id_p1;
endmodule

// File: doc/loa_add_arbiter.md
LOA_ADD_ARBITER -- requirements
Module: loa_add_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 Parameter WIDTH, default 16: operand and result width.
REQ-003 Parameter LOA_BITS, default 8: width of the OR-approximated lower part, 1..WIDTH-1.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 approx_en  input  1  1 = LOA approximate add, 0 = exact add; sampled at grant.
REQ-007 req_valid  input  NREQ  per-requester operand-valid.
REQ-008 req_a  input  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
REQ-009 req_b  input  NREQ*WIDTH  operand B, same packing.
REQ-010 req_ready  output  NREQ  one-hot grant/accept, combinational.
REQ-011 res_valid  output  1  registered result valid.
REQ-012 res_data  output  WIDTH  registered sum.
REQ-013 res_cout  output  1  registered carry-out of the top bit.
REQ-014 res_id  output  $clog2(NREQ)  index of the requester that owns res_data.
REQ-015 res_ready  input  1  consumer accepts the result.

Function
REQ-016 The block shall share one adder datapath among NREQ requesters; at most one transfer per cycle.
REQ-017 Accept condition: adder_free = !res_valid || res_ready.
REQ-018 req_ready[i] shall be 1 only when adder_free is 1, req_valid[i] is 1, and i is the round-robin winner; all other bits shall be 0.
REQ-019 req_ready shall never assert for a requester with req_valid low.
REQ-020 Transfer on requester i occurs when req_valid[i] and req_ready[i] are both 1 at a rising edge.
REQ-021 Round-robin order: search starts at last_grant+1 mod NREQ and proceeds upward with wrap-around; the first valid requester wins.
REQ-022 last_grant shall update only on a transfer.
REQ-023 Latency: result for a transfer shall appear on res_data, res_cout and res_id with res_valid=1 on the next cycle.
REQ-024 res_valid, res_data, res_cout and res_id shall hold stable while res_valid=1 and res_ready=0.
REQ-025 On res_ready=1 with no new transfer, res_valid shall clear next cycle.
REQ-026 Simultaneous res_ready=1 and a new transfer shall load the new result with no bubble.
REQ-027 Approximate mode, lower bits [LOA_BITS-1:0]: sum = A | B, bitwise.
REQ-028 Approximate mode, upper part: A[WIDTH-1:LOA_BITS] + B[WIDTH-1:LOA_BITS] + (A[LOA_BITS-1] & B[LOA_BITS-1]); res_cout is its carry-out.
REQ-029 Exact mode: {res_cout, res_data} = A + B, full (WIDTH+1)-bit sum.
REQ-030 A change of approx_en shall affect only transfers granted after the change, never a held result.
REQ-031 Requesters not granted shall keep their request pending; operands are not captured until transfer.

Reset
REQ-032 While rst_n=0, the outputs shall be: res_valid=0, res_data=0, res_cout=0, res_id=0, and req_ready all 0.
REQ-033 While rst_n=0, last_grant shall be NREQ-1, so requester 0 has first priority after release.
REQ-034 Reset asserted mid-operation shall discard any held result immediately, asynchronously.
REQ-035 The first transfer is permitted on the first rising edge with rst_n=1.

Verification
REQ-036 Approximate add: req 0, approx_en=1, A=0x0080, B=0x0080 -> next cycle res_data=0x0180, res_cout=0, res_id=0.
REQ-037 Exact add: same operands with approx_en=0 -> res_data=0x0100.
REQ-038 No lower-part carry: A=0x00FF, B=0x0001 -> approx res_data=0x00FF, exact res_data=0x0100.
REQ-039 Carry-out: A=0xFF00, B=0x0100, either mode -> res_data=0x0000, res_cout=1.
REQ-040 Arbitration fairness: all 4 req_valid held high, res_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, one result per cycle.
REQ-041 Backpressure and reset: res_ready=0 for 3 cycles -> req_ready all 0 and the result is held; then pulse rst_n low -> res_valid=0 at once, and the first grant after release goes to requester 0.
